// File: rtl/div_if.sv
// rtl/div_if.sv - execute-stage to divider request/result bundle
interface div_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div.sv
// rtl/div.sv - 32-step restoring divider for DIV/DIVU, result {remainder, quotient}
module div (
   input  logic clk,
   input  logic rst,
   div_if.slave bus
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_rem, w_rem_nxt;
   logic [31:0] r_quo, w_quo_nxt;
   logic [31:0] r_dvs, w_dvs_nxt;
   logic        r_sgn, w_sgn_nxt;
   logic        r_neg1, w_neg1_nxt;
   logic        r_neg2, w_neg2_nxt;
   logic [63:0] r_result, w_result_nxt;
   logic        r_ready, w_ready_nxt;

   logic [32:0] w_t;
   logic [31:0] w_mag1, w_mag2;
   logic [31:0] w_quo_fix, w_rem_fix;

   // 0x80000000 negates to itself and is then treated as an unsigned magnitude
   assign w_mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
   assign w_mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

   assign w_t       = {r_rem, r_quo[31]} - {1'b0, r_dvs};
   assign w_quo_fix = (r_sgn && (r_neg1 ^ r_neg2)) ? (~r_quo + 32'd1) : r_quo;
   assign w_rem_fix = (r_sgn && r_neg1) ? (~r_rem + 32'd1) : r_rem;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_rem_nxt    = r_rem;
      w_quo_nxt    = r_quo;
      w_dvs_nxt    = r_dvs;
      w_sgn_nxt    = r_sgn;
      w_neg1_nxt   = r_neg1;
      w_neg2_nxt   = r_neg2;
      w_result_nxt = r_result;
      w_ready_nxt  = r_ready;
      case (r_state)
         FREE: begin
            w_result_nxt = 64'd0;
            w_ready_nxt  = 1'b0;
            if (bus.start_i && !bus.annul_i) begin
               if (bus.opdata2_i == 32'd0) begin
                  w_state_nxt = BYZERO;
               end else begin
                  w_state_nxt = ON;
                  w_sgn_nxt   = bus.signed_div_i;
                  w_neg1_nxt  = bus.opdata1_i[31];
                  w_neg2_nxt  = bus.opdata2_i[31];
                  w_dvs_nxt   = w_mag2;
                  w_quo_nxt   = w_mag1;
                  w_rem_nxt   = 32'd0;
                  w_cnt_nxt   = 6'd0;
               end
            end
         end
         BYZERO: begin
            w_state_nxt  = END;
            w_result_nxt = 64'd0;
            w_ready_nxt  = 1'b1;
         end
         ON: begin
            if (bus.annul_i) begin
               w_state_nxt  = FREE;
               w_cnt_nxt    = 6'd0;
               w_ready_nxt  = 1'b0;
               w_result_nxt = 64'd0;
            end else if (r_cnt != 6'd32) begin
               if (!w_t[32]) begin
                  w_rem_nxt = w_t[31:0];
                  w_quo_nxt = {r_quo[30:0], 1'b1};
               end else begin
                  w_rem_nxt = {r_rem[30:0], r_quo[31]};
                  w_quo_nxt = {r_quo[30:0], 1'b0};
               end
               w_cnt_nxt = r_cnt + 6'd1;
            end else begin
               w_state_nxt  = END;
               w_ready_nxt  = 1'b1;
               w_result_nxt = {w_rem_fix, w_quo_fix};
            end
         end
         END: begin
            if (!bus.start_i) begin
               w_state_nxt  = FREE;
               w_ready_nxt  = 1'b0;
               w_result_nxt = 64'd0;
            end
         end
         default: begin
            w_state_nxt  = FREE;
            w_ready_nxt  = 1'b0;
            w_result_nxt = 64'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= FREE;
         r_cnt    <= 6'd0;
         r_rem    <= 32'd0;
         r_quo    <= 32'd0;
         r_dvs    <= 32'd0;
         r_sgn    <= 1'b0;
         r_neg1   <= 1'b0;
         r_neg2   <= 1'b0;
         r_result <= 64'd0;
         r_ready  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rem    <= w_rem_nxt;
         r_quo    <= w_quo_nxt;
         r_dvs    <= w_dvs_nxt;
         r_sgn    <= w_sgn_nxt;
         r_neg1   <= w_neg1_nxt;
         r_neg2   <= w_neg2_nxt;
         r_result <= w_result_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

   assign bus.result_o = r_result;
   assign bus.ready_o  = r_ready;

endmodule
